// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch front end: reset PC, FSM states and queue entry layout.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          ENTRY_W      = 64;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Circular queue of {pc, instr} entries between fetch and decode.
// Flush clears occupancy in one cycle; the head reads as zero while empty.
module fetch_unit_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          full_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_s || do_pop_s);
    assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC owner and instruction-fetch front end: issues 1-cycle imem reads, queues {pc,instr} for decode.
// Optional macro FETCH_ALIGN_CHK_EN: a misaligned redirect raises sticky exc_adel and halts fetch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        exc_adel
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_e  state_q;
    logic [31:0]   pc_q;
    logic [31:0]   req_addr_q;
    logic          inflight_q;
    logic          tag_q;
    logic          epoch_q;
    logic          exc_q;

    logic [CW-1:0] fifo_count_s;
    logic          fifo_empty_s;
    fetch_entry_t  fifo_head_s;
    fetch_entry_t  push_data_s;
    logic          push_s;
    logic          pop_s;
    logic          issue_room_s;
    logic          misalign_s;
    logic [31:0]   redir_target_s;

`ifdef FETCH_ALIGN_CHK_EN
    assign misalign_s     = redir_valid && (redir_pc[1:0] != 2'b00);
    assign redir_target_s = redir_pc;
`else
    assign misalign_s     = 1'b0;
    assign redir_target_s = word_align(redir_pc);
`endif

    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign exc_adel    = exc_q;
    assign id_valid    = !fifo_empty_s;
    assign id_pc       = fifo_head_s.pc;
    assign id_instr    = fifo_head_s.instr;
    assign pop_s       = id_valid && id_ready;
    assign push_data_s = '{pc: req_addr_q, instr: imem_rdata};
    // A redirect in the response cycle drops the response along with the queue.
    assign push_s      = inflight_q && (tag_q == epoch_q) && !redir_valid;

    // Issue only if the response is guaranteed a slot after this cycle's pop.
    always_comb begin
        issue_room_s = 1'b0;
        if ((OW'(fifo_count_s) + OW'(inflight_q)) < (OW'(FIFO_DEPTH) + OW'(pop_s))) begin
            issue_room_s = 1'b1;
        end else begin
            issue_room_s = 1'b0;
        end
    end

    // Read strobe toward instruction memory.
    always_comb begin
        imem_req = 1'b0;
        if ((state_q == S_RUN) && !redir_valid && issue_room_s) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    // Fetch FSM with PC, epoch and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= 32'h0000_0000;
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
            epoch_q    <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            case (state_q)
                S_BOOT, S_RUN: begin
                    if (redir_valid) begin
                        epoch_q    <= ~epoch_q;
                        inflight_q <= 1'b0;
                        pc_q       <= redir_target_s;
                        if (misalign_s) begin
                            state_q <= S_HALT;
                            exc_q   <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else begin
                        state_q    <= S_RUN;
                        inflight_q <= imem_req;
                        if (imem_req) begin
                            pc_q       <= pc_q + 32'd4;
                            req_addr_q <= pc_q;
                            tag_q      <= epoch_q;
                        end
                    end
                end
                S_HALT: begin
                    inflight_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_BOOT;
                    inflight_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_unit_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_s),
        .push_data_i(push_data_s),
        .pop_i      (pop_s),
        .flush_i    (redir_valid),
        .head_o     (fifo_head_s),
        .count_o    (fifo_count_s),
        .empty_o    (fifo_empty_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model checked every cycle,
// plus literal address/order expectations for boot, stall, redirect, wrap, alignment and reset.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_out;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        exc_adel;

    int n_tests;
    int n_fail;
    int cyc;
    int rel_cyc;

    // reference model state
    bit          m_run;
    bit          m_halt;
    bit          m_exc;
    bit          m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    logic [31:0] mq_pc[$];
    logic [31:0] mq_instr[$];

    // observation logs
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] dlv_log[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_3000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_out     (pc_out),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .exc_adel   (exc_adel)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // instruction memory: one-cycle synchronous read
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_halt = 1'b0;
        m_exc  = 1'b0;
        m_pend = 1'b0;
        m_pc   = 32'h0000_3000;
        mq_pc.delete();
        mq_instr.delete();
    endtask

    // Per-cycle compare against the model, then advance the model over the next posedge.
    always begin : cmp
        bit pop_e;
        bit req_e;
        int occ_e;
        @(negedge clk);
        #2;
        cyc++;
        if (!rst_n) begin
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_id_valid", 32'(id_valid), 32'd0);
            chk("rst_id_pc", id_pc, 32'd0);
            chk("rst_id_instr", id_instr, 32'd0);
            chk("rst_exc_adel", 32'(exc_adel), 32'd0);
            chk("rst_pc_out", pc_out, 32'h0000_3000);
            model_reset();
        end else begin
            pop_e = (mq_pc.size() > 0) && id_ready;
            occ_e = mq_pc.size() + (m_pend ? 1 : 0) - (pop_e ? 1 : 0);
            req_e = m_run && !m_halt && !redir_valid && (occ_e < DEPTH);
            chk("imem_req", 32'(imem_req), 32'(req_e));
            chk("pc_out", pc_out, m_pc);
            if (req_e) chk("imem_addr", imem_addr, m_pc);
            chk("id_valid", 32'(id_valid), 32'(mq_pc.size() > 0));
            if (mq_pc.size() > 0) begin
                chk("id_pc", id_pc, mq_pc[0]);
                chk("id_instr", id_instr, mq_instr[0]);
            end
            chk("exc_adel", 32'(exc_adel), 32'(m_exc));
            if (imem_req) begin
                req_log.push_back(imem_addr);
                req_cyc.push_back(cyc);
            end
            if (id_valid && id_ready) dlv_log.push_back(id_pc);
            if (pop_e) begin
                void'(mq_pc.pop_front());
                void'(mq_instr.pop_front());
            end
            if (m_halt) begin
                m_pend = 1'b0;
            end else if (redir_valid) begin
                mq_pc.delete();
                mq_instr.delete();
                m_pend = 1'b0;
                m_run  = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
                m_pc = redir_pc;
                if (redir_pc % 32'd4 != 32'd0) begin
                    m_halt = 1'b1;
                    m_exc  = 1'b1;
                end
`else
                m_pc = redir_pc - (redir_pc % 32'd4);
`endif
            end else begin
                if (m_pend) begin
                    mq_pc.push_back(m_pend_pc);
                    mq_instr.push_back(mem_word(m_pend_pc));
                end
                m_pend = req_e;
                if (req_e) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
                m_run = 1'b1;
            end
        end
    end

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        dlv_log.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_logs();
        rst_n   = 1'b1;
        rel_cyc = cyc + 1;
    endtask

    task automatic redirect(input logic [31:0] target);
        @(negedge clk);
        clear_logs();
        redir_valid = 1'b1;
        redir_pc    = target;
        @(negedge clk);
        redir_valid = 1'b0;
    endtask

    initial begin
        int n3004;
        int n3008;
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        rel_cyc     = 0;
        redir_valid = 1'b0;
        redir_pc    = 32'd0;
        id_ready    = 1'b1;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // boot: no request in cycle 1, then back-to-back 0x3000, 0x3004, 0x3008
        do_reset();
        repeat (7) @(negedge clk);
        #3;
        chk("boot_nreq", 32'(req_log.size() >= 3), 32'd1);
        chk("boot_ndlv", 32'(dlv_log.size() >= 3), 32'd1);
        if (req_log.size() >= 3 && dlv_log.size() >= 3) begin
            chk("boot_req0", req_log[0], 32'h0000_3000);
            chk("boot_req1", req_log[1], 32'h0000_3004);
            chk("boot_req2", req_log[2], 32'h0000_3008);
            chk("boot_req0_cyc", 32'(req_cyc[0]), 32'(rel_cyc + 1));
            chk("boot_b2b1", 32'(req_cyc[1]), 32'(req_cyc[0] + 1));
            chk("boot_b2b2", 32'(req_cyc[2]), 32'(req_cyc[1] + 1));
            chk("boot_dlv0", dlv_log[0], 32'h0000_3000);
            chk("boot_dlv1", dlv_log[1], 32'h0000_3004);
            chk("boot_dlv2", dlv_log[2], 32'h0000_3008);
        end

        // stall: decode not ready -> two entries queued, fetch stops
        id_ready = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        #3;
        chk("stall_nreq", 32'(req_log.size()), 32'd2);
        chk("stall_req_now", 32'(imem_req), 32'd0);
        chk("stall_id_valid", 32'(id_valid), 32'd1);
        chk("stall_id_pc", id_pc, 32'h0000_3000);
        chk("stall_id_instr", id_instr, 32'h5A5A_3F0F);
        @(negedge clk);
        id_ready = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        chk("drain_ndlv", 32'(dlv_log.size() >= 3), 32'd1);
        if (dlv_log.size() >= 3) begin
            chk("drain_dlv0", dlv_log[0], 32'h0000_3000);
            chk("drain_dlv1", dlv_log[1], 32'h0000_3004);
            chk("drain_dlv2", dlv_log[2], 32'h0000_3008);
        end

        // redirect while 0x3008 in flight, same cycle as 0x3004 handshake
        do_reset();
        repeat (4) @(negedge clk);
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_3100;
        @(negedge clk);
        redir_valid = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        n3004 = 0;
        n3008 = 0;
        foreach (dlv_log[i]) begin
            if (dlv_log[i] == 32'h0000_3004) n3004++;
            if (dlv_log[i] == 32'h0000_3008) n3008++;
        end
        chk("redir_drop_3008", 32'(n3008), 32'd0);
        chk("redir_dlv_3004_once", 32'(n3004), 32'd1);
        chk("redir_nreq", 32'(req_log.size() >= 4), 32'd1);
        chk("redir_ndlv", 32'(dlv_log.size() >= 3), 32'd1);
        if (req_log.size() >= 4 && dlv_log.size() >= 3) begin
            chk("redir_req3", req_log[3], 32'h0000_3100);
            chk("redir_req3_cyc", 32'(req_cyc[3]), 32'(rel_cyc + 5));
            chk("redir_dlv2", dlv_log[2], 32'h0000_3100);
        end

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFFC);
        repeat (4) @(negedge clk);
        #3;
        chk("wrap_nreq", 32'(req_log.size() >= 2), 32'd1);
        if (req_log.size() >= 2) begin
            chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
            chk("wrap_req1", req_log[1], 32'h0000_0000);
        end
        chk("wrap_exc", 32'(exc_adel), 32'd0);

        // misaligned redirect
        redirect(32'h0000_3102);
        repeat (3) @(negedge clk);
        #3;
`ifdef FETCH_ALIGN_CHK_EN
        chk("adel_exc", 32'(exc_adel), 32'd1);
        chk("adel_req", 32'(imem_req), 32'd0);
        chk("adel_id_valid", 32'(id_valid), 32'd0);
        chk("adel_nreq", 32'(req_log.size()), 32'd0);
`else
        chk("align_nreq", 32'(req_log.size() >= 1), 32'd1);
        if (req_log.size() >= 1) chk("align_req0", req_log[0], 32'h0000_3100);
        chk("align_exc", 32'(exc_adel), 32'd0);
`endif

        // asynchronous reset mid-stream, between clock edges
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(imem_req), 32'd0);
        chk("async_rst_valid", 32'(id_valid), 32'd0);
        chk("async_rst_id_pc", id_pc, 32'd0);
        chk("async_rst_id_instr", id_instr, 32'd0);
        chk("async_rst_exc", 32'(exc_adel), 32'd0);
        chk("async_rst_pc", pc_out, 32'h0000_3000);
        @(negedge clk);
        @(negedge clk);
        clear_logs();
        rst_n   = 1'b1;
        rel_cyc = cyc + 1;
        repeat (4) @(negedge clk);
        #3;
        chk("restart_nreq", 32'(req_log.size() >= 1), 32'd1);
        if (req_log.size() >= 1) begin
            chk("restart_req0", req_log[0], 32'h0000_3000);
            chk("restart_req0_cyc", 32'(req_cyc[0]), 32'(rel_cyc + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
